// File: rtl/game_pkg.sv
// Shared types and defaults for the ball engine: angle codes, per-ball FSM
// states, playfield defaults and the LFSR helpers.
package game_pkg;

   typedef enum logic [1:0] {
      ANG_1_1  = 2'b00,
      ANG_1_2  = 2'b01,
      ANG_1_3  = 2'b10,
      ANG_RAND = 2'b11
   } angle_e;

   typedef enum logic {
      IDLE = 1'b0,
      MOVE = 1'b1
   } ball_state_e;

   localparam int DEF_NUM_BALLS   = 2;
   localparam int DEF_XW          = 10;
   localparam int DEF_YW          = 10;
   localparam int DEF_FIELD_W     = 640;
   localparam int DEF_FIELD_H     = 480;
   localparam int DEF_BORDER      = 30;
   localparam int DEF_GOAL_MARGIN = 15;
   localparam int DEF_TICK_DIV    = 100000;
   localparam int DEF_SERVE_X     = 320;
   localparam int DEF_SERVE_Y     = 240;

   localparam logic [4:0] LFSR_SEED = 5'b00001;

   // x^5 + x^3 + 1, maximal length over the 31 non-zero states
   function automatic logic [4:0] lfsr_next(input logic [4:0] s);
      return {s[3:0], s[4] ^ s[2]};
   endfunction

   function automatic logic [1:0] rand_limit(input logic [1:0] s);
      return (s == 2'd3) ? 2'd2 : s;
   endfunction

endpackage

// File: rtl/ball_channel.sv
// One ball: IDLE/MOVE FSM, position, headings, y step counter, wall and goal events.
// Optional hit-count speed ramp under BALL_ENGINE_SPEED_RAMP_EN.
//
// state | meaning
// IDLE  | ball out of play, position frozen at last value
// MOVE  | ball in play, advancing on move ticks
module ball_channel
   import game_pkg::*;
#(
   parameter int XW          = DEF_XW,
   parameter int YW          = DEF_YW,
   parameter int FIELD_W     = DEF_FIELD_W,
   parameter int FIELD_H     = DEF_FIELD_H,
   parameter int BORDER      = DEF_BORDER,
   parameter int GOAL_MARGIN = DEF_GOAL_MARGIN,
   parameter int SERVE_X     = DEF_SERVE_X,
   parameter int SERVE_Y     = DEF_SERVE_Y
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_tick,
   input  logic          i_pace,
   input  logic [1:0]    i_angle_sel,
   input  logic [1:0]    i_lfsr_lo,
   input  logic          i_serve_req,
   input  logic          i_serve_dir,
   input  logic          i_hit,
   input  logic          i_hit_dir,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_active,
   output logic          o_wall,
   output logic          o_out_left,
   output logic          o_out_right,
   output logic          o_hit_acc
`ifdef BALL_ENGINE_SPEED_RAMP_EN
  ,output logic          o_boosted
`endif
);

   localparam logic [XW-1:0] L_SERVE_X = XW'(SERVE_X);
   localparam logic [YW-1:0] L_SERVE_Y = YW'(SERVE_Y);
   localparam logic [XW-1:0] L_OUT_L   = XW'(GOAL_MARGIN);
   localparam logic [XW-1:0] L_OUT_R   = XW'(FIELD_W - 1 - GOAL_MARGIN);
   localparam logic [YW-1:0] L_TOP     = YW'(BORDER);
   localparam logic [YW-1:0] L_BOT     = YW'(FIELD_H - BORDER);
   localparam logic [YW-1:0] L_TOP_FIX = YW'(BORDER + 1);
   localparam logic [YW-1:0] L_BOT_FIX = YW'(FIELD_H - BORDER - 1);

   ball_state_e   r_state, w_state_nxt;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          r_dir_x, r_dir_y;
   logic [1:0]    r_step, r_rand_lim, w_lim;
   logic          r_wall, r_out_l, r_out_r;
   logic          w_live, w_hit, w_out_l, w_out_r, w_wall_t, w_wall_b;
   logic          w_out, w_move, w_boost, w_y_step;
   logic          w_wall_nxt, w_out_l_nxt, w_out_r_nxt;

   // serve_req pre-empts every other event; a hit cancels the goal check
   assign w_live   = (r_state == MOVE) && !i_serve_req;
   assign w_hit    = w_live && i_hit;
   assign w_out_l  = w_live && !i_hit && (r_x <= L_OUT_L);
   assign w_out_r  = w_live && !i_hit && (r_x >= L_OUT_R);
   assign w_out    = w_out_l || w_out_r;
   assign w_wall_t = w_live && (r_y <= L_TOP);
   assign w_wall_b = w_live && (r_y >= L_BOT);
   assign w_move   = w_live && !w_out && i_tick && (i_pace || w_boost);
   assign w_y_step = w_move && (r_step == w_lim);

   always_comb begin
      w_lim = 2'd0;
      case (angle_e'(i_angle_sel))
         ANG_1_1:  w_lim = 2'd0;
         ANG_1_2:  w_lim = 2'd1;
         ANG_1_3:  w_lim = 2'd2;
         default:  w_lim = r_rand_lim;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_serve_req) w_state_nxt = MOVE;
         MOVE:    if (w_out)       w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_active    = (r_state == MOVE);
      o_hit_acc   = w_hit;
      w_wall_nxt  = w_wall_t || w_wall_b;
      w_out_l_nxt = w_out_l;
      w_out_r_nxt = w_out_r;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x        <= L_SERVE_X;
         r_y        <= L_SERVE_Y;
         r_dir_x    <= 1'b1;
         r_dir_y    <= 1'b1;
         r_step     <= 2'd0;
         r_rand_lim <= 2'd0;
         r_wall     <= 1'b0;
         r_out_l    <= 1'b0;
         r_out_r    <= 1'b0;
      end else begin
         r_wall  <= w_wall_nxt;
         r_out_l <= w_out_l_nxt;
         r_out_r <= w_out_r_nxt;
         if (i_serve_req) begin
            r_x        <= L_SERVE_X;
            r_y        <= L_SERVE_Y;
            r_dir_x    <= i_serve_dir;
            r_dir_y    <= 1'b1;
            r_step     <= 2'd0;
            r_rand_lim <= rand_limit(i_lfsr_lo);
         end else if (r_state == MOVE) begin
            if (w_hit) begin
               r_dir_x    <= i_hit_dir;
               r_x        <= i_hit_dir ? r_x + XW'(1) : r_x - XW'(1);
               r_rand_lim <= rand_limit(i_lfsr_lo);
            end else if (w_move) begin
               r_x <= r_dir_x ? r_x + XW'(1) : r_x - XW'(1);
            end
            if (w_move) r_step <= w_y_step ? 2'd0 : r_step + 2'd1;
            // wall correction overrides any y step landing in the same cycle
            if (w_wall_t) begin
               r_dir_y <= 1'b1;
               r_y     <= L_TOP_FIX;
            end else if (w_wall_b) begin
               r_dir_y <= 1'b0;
               r_y     <= L_BOT_FIX;
            end else if (w_y_step) begin
               r_y <= r_dir_y ? r_y + YW'(1) : r_y - YW'(1);
            end
         end
      end
   end

`ifdef BALL_ENGINE_SPEED_RAMP_EN
   logic [2:0] r_hits;
   assign w_boost   = (r_hits == 3'd4);
   assign o_boosted = w_boost;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_hits <= 3'd0;
      else if (i_serve_req)        r_hits <= 3'd0;
      else if (w_hit && !w_boost)  r_hits <= r_hits + 3'd1;
   end
`else
   assign w_boost = 1'b0;
`endif

   assign o_x         = r_x;
   assign o_y         = r_y;
   assign o_wall      = r_wall;
   assign o_out_left  = r_out_l;
   assign o_out_right = r_out_r;

endmodule

// File: rtl/ball_engine.sv
// Multi-ball motion engine: shared tick prescaler, pacing phase, hit LFSR and output packing.
// Define BALL_ENGINE_SPEED_RAMP_EN to add the per-ball hit-count speed ramp and boosted port.
module ball_engine
   import game_pkg::*;
#(
   parameter int NUM_BALLS   = DEF_NUM_BALLS,
   parameter int XW          = DEF_XW,
   parameter int YW          = DEF_YW,
   parameter int FIELD_W     = DEF_FIELD_W,
   parameter int FIELD_H     = DEF_FIELD_H,
   parameter int BORDER      = DEF_BORDER,
   parameter int GOAL_MARGIN = DEF_GOAL_MARGIN,
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int SERVE_X     = DEF_SERVE_X,
   parameter int SERVE_Y     = DEF_SERVE_Y
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    fast,
   input  logic [1:0]              angle_sel,
   input  logic [NUM_BALLS-1:0]    serve_req,
   input  logic [NUM_BALLS-1:0]    serve_dir,
   input  logic [NUM_BALLS-1:0]    hit,
   input  logic [NUM_BALLS-1:0]    hit_dir,
   output logic [NUM_BALLS*XW-1:0] ball_x,
   output logic [NUM_BALLS*YW-1:0] ball_y,
   output logic [NUM_BALLS-1:0]    active,
   output logic [NUM_BALLS-1:0]    wall,
   output logic [NUM_BALLS-1:0]    out_left,
   output logic [NUM_BALLS-1:0]    out_right
`ifdef BALL_ENGINE_SPEED_RAMP_EN
  ,output logic [NUM_BALLS-1:0]    boosted
`endif
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] L_PS_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]        r_ps;
   logic                 r_phase;
   logic [4:0]           r_lfsr;
   logic                 w_tick, w_pace;
   logic [NUM_BALLS-1:0] w_hit_acc;

   assign w_tick = enable && (r_ps == L_PS_LAST);
   assign w_pace = fast || !r_phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ps    <= '0;
         r_phase <= 1'b0;
      end else if (enable) begin
         r_ps <= (r_ps == L_PS_LAST) ? '0 : r_ps + PW'(1);
         if (w_tick) r_phase <= ~r_phase;
      end
   end

   // one advance per cycle even when several balls are hit together
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_lfsr <= LFSR_SEED;
      else if (|w_hit_acc) r_lfsr <= lfsr_next(r_lfsr);
   end

   for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
      ball_channel #(
         .XW(XW), .YW(YW), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H),
         .BORDER(BORDER), .GOAL_MARGIN(GOAL_MARGIN),
         .SERVE_X(SERVE_X), .SERVE_Y(SERVE_Y)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .i_tick      (w_tick),
         .i_pace      (w_pace),
         .i_angle_sel (angle_sel),
         .i_lfsr_lo   (r_lfsr[1:0]),
         .i_serve_req (serve_req[g]),
         .i_serve_dir (serve_dir[g]),
         .i_hit       (hit[g]),
         .i_hit_dir   (hit_dir[g]),
         .o_x         (ball_x[g*XW +: XW]),
         .o_y         (ball_y[g*YW +: YW]),
         .o_active    (active[g]),
         .o_wall      (wall[g]),
         .o_out_left  (out_left[g]),
         .o_out_right (out_right[g]),
         .o_hit_acc   (w_hit_acc[g])
`ifdef BALL_ENGINE_SPEED_RAMP_EN
        ,.o_boosted   (boosted[g])
`endif
      );
   end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: three balls, four-cycle tick, hand-computed positions.
module tb_ball_engine;
   localparam int NB = 3;
   localparam int XW = 10;
   localparam int YW = 10;
   localparam int TD = 4;

   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, fast = 1'b0;
   logic [1:0] angle_sel = 2'b00;
   logic [NB-1:0] serve_req = '0, serve_dir = '0, hit = '0, hit_dir = '0;
   logic [NB*XW-1:0] ball_x;
   logic [NB*YW-1:0] ball_y;
   logic [NB-1:0] active, wall, out_left, out_right;
`ifdef BALL_ENGINE_SPEED_RAMP_EN
   logic [NB-1:0] boosted;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   ball_engine #(.NUM_BALLS(NB), .XW(XW), .YW(YW), .TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fast(fast), .angle_sel(angle_sel),
      .serve_req(serve_req), .serve_dir(serve_dir), .hit(hit), .hit_dir(hit_dir),
      .ball_x(ball_x), .ball_y(ball_y), .active(active), .wall(wall),
      .out_left(out_left), .out_right(out_right)
`ifdef BALL_ENGINE_SPEED_RAMP_EN
     ,.boosted(boosted)
`endif
   );

   always #5 clk = ~clk;

   function automatic int bx(input int b);
      return int'(ball_x[b*XW +: XW]);
   endfunction

   function automatic int by(input int b);
      return int'(ball_y[b*YW +: YW]);
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // windows are whole multiples of TD, so the prescaler always restarts at 0
   // and each tick lands on the last edge of its window
   task automatic run_ticks(input int n);
      enable = 1'b1;
      step(n * TD);
      enable = 1'b0;
   endtask

   task automatic serve(input int b, input logic dir);
      serve_req[b] = 1'b1;
      serve_dir[b] = dir;
      step(1);
      serve_req = '0;
   endtask

   task automatic test_reset;
      step(2);
      for (int b = 0; b < NB; b++) begin
         n_checks++;
         if (bx(b) !== 320) $display("FAIL rst_x%0d got %0d want 320", b, bx(b));
         else n_pass++;
         n_checks++;
         if (by(b) !== 240) $display("FAIL rst_y%0d got %0d want 240", b, by(b));
         else n_pass++;
      end
      n_checks++;
      if ({active, wall, out_left, out_right} !== '0)
         $display("FAIL rst_flags got %b want 0", {active, wall, out_left, out_right});
      else n_pass++;
      rst = 1'b0;
      step(1);

      fast = 1'b1; angle_sel = 2'b00;
      serve(0, 1'b1);
      run_ticks(80);
      n_checks++;
      if (bx(0) !== 400 || active[0] !== 1'b1)
         $display("FAIL midflight x got %0d act %b want 400 act 1", bx(0), active[0]);
      else n_pass++;
      rst = 1'b1;
      step(1);
      n_checks++;
      if (bx(0) !== 320 || active !== '0 || {wall, out_left, out_right} !== '0)
         $display("FAIL midrst got x %0d act %b pulses %b want 320 0 0",
                  bx(0), active, {wall, out_left, out_right});
      else n_pass++;
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_straight;
      fast = 1'b1; angle_sel = 2'b00;
      serve(0, 1'b1);
      n_checks++;
      if (active[0] !== 1'b1 || bx(0) !== 320)
         $display("FAIL serve got act %b x %0d want 1 320", active[0], bx(0));
      else n_pass++;
      run_ticks(8);
      n_checks++;
      if (bx(0) !== 328 || by(0) !== 248)
         $display("FAIL straight got %0d/%0d want 328/248", bx(0), by(0));
      else n_pass++;
   endtask

   task automatic test_ratio_slow;
      fast = 1'b0; angle_sel = 2'b01;
      serve(0, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         run_ticks(1);
         n_checks++;
         if (bx(0) !== 320 + (k + 1) / 2)
            $display("FAIL slow_x tick %0d got %0d want %0d", k, bx(0), 320 + (k + 1) / 2);
         else n_pass++;
      end
      n_checks++;
      if (by(0) !== 243) $display("FAIL ratio_y got %0d want 243", by(0));
      else n_pass++;
   endtask

   task automatic test_bottom_wall;
      fast = 1'b1; angle_sel = 2'b00;
      serve(0, 1'b1);
      run_ticks(209);
      n_checks++;
      if (by(0) !== 449 || bx(0) !== 529 || wall[0] !== 1'b0)
         $display("FAIL pre_wall got %0d/%0d wall %b want 529/449 0", bx(0), by(0), wall[0]);
      else n_pass++;
      run_ticks(1);
      n_checks++;
      if (by(0) !== 450 || wall[0] !== 1'b0)
         $display("FAIL wall_hit got y %0d wall %b want 450 0", by(0), wall[0]);
      else n_pass++;
      step(1);
      n_checks++;
      if (by(0) !== 449 || wall[0] !== 1'b1)
         $display("FAIL wall_fix got y %0d wall %b want 449 1", by(0), wall[0]);
      else n_pass++;
      step(1);
      n_checks++;
      if (by(0) !== 449 || wall[0] !== 1'b0)
         $display("FAIL wall_once got y %0d wall %b want 449 0", by(0), wall[0]);
      else n_pass++;
      run_ticks(1);
      n_checks++;
      if (by(0) !== 448) $display("FAIL wall_dir got y %0d want 448", by(0));
      else n_pass++;
   endtask

   task automatic test_out_hit;
      fast = 1'b1; angle_sel = 2'b10;
      serve(0, 1'b0);
      run_ticks(305);
      n_checks++;
      if (bx(0) !== 15 || active[0] !== 1'b1 || out_left[0] !== 1'b0)
         $display("FAIL at_goal got x %0d act %b out %b want 15 1 0", bx(0), active[0], out_left[0]);
      else n_pass++;
      step(1);
      n_checks++;
      if (out_left[0] !== 1'b1 || active[0] !== 1'b0 || bx(0) !== 15)
         $display("FAIL out_left got out %b act %b x %0d want 1 0 15", out_left[0], active[0], bx(0));
      else n_pass++;
      step(1);
      n_checks++;
      if (out_left[0] !== 1'b0) $display("FAIL out_once got %b want 0", out_left[0]);
      else n_pass++;

      serve(0, 1'b0);
      run_ticks(305);
      hit[0] = 1'b1; hit_dir[0] = 1'b1;
      step(1);
      hit = '0;
      n_checks++;
      if (bx(0) !== 16 || active[0] !== 1'b1 || out_left[0] !== 1'b0)
         $display("FAIL hit_wins got x %0d act %b out %b want 16 1 0", bx(0), active[0], out_left[0]);
      else n_pass++;
      step(1);
      n_checks++;
      if (out_left[0] !== 1'b0 || active[0] !== 1'b1)
         $display("FAIL hit_after got out %b act %b want 0 1", out_left[0], active[0]);
      else n_pass++;

      hit[1] = 1'b1; hit_dir[1] = 1'b1;
      step(1);
      hit = '0;
      n_checks++;
      if (bx(1) !== 320 || active[1] !== 1'b0)
         $display("FAIL idle_hit got x %0d act %b want 320 0", bx(1), active[1]);
      else n_pass++;
   endtask

   task automatic test_multi;
      fast = 1'b1; angle_sel = 2'b10;
      serve_req = 3'b101; serve_dir = 3'b100;
      step(1);
      serve_req = '0;
      run_ticks(304);
      n_checks++;
      if (bx(0) !== 16 || bx(2) !== 624 || by(0) !== 341 || by(2) !== 341)
         $display("FAIL multi_pos got %0d/%0d %0d/%0d want 16/341 624/341", bx(0), by(0), bx(2), by(2));
      else n_pass++;
      n_checks++;
      if (active !== 3'b101 || out_right !== 3'b000)
         $display("FAIL multi_act got %b out_r %b want 101 000", active, out_right);
      else n_pass++;
      step(1);
      n_checks++;
      if (out_right !== 3'b100 || active !== 3'b001 || out_left !== 3'b000)
         $display("FAIL out_right got out_r %b act %b out_l %b want 100 001 000", out_right, active, out_left);
      else n_pass++;
      n_checks++;
      if (bx(1) !== 320 || by(1) !== 240)
         $display("FAIL ball1_idle got %0d/%0d want 320/240", bx(1), by(1));
      else n_pass++;
      run_ticks(1);
      n_checks++;
      if (bx(0) !== 15 || bx(2) !== 624 || out_right !== 3'b000)
         $display("FAIL indep got x0 %0d x2 %0d out_r %b want 15 624 000", bx(0), bx(2), out_right);
      else n_pass++;
      step(1);
      n_checks++;
      if (out_left !== 3'b001 || active !== 3'b000)
         $display("FAIL multi_left got out_l %b act %b want 001 000", out_left, active);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_straight();
      test_ratio_slow();
      test_bottom_wall();
      test_out_hit();
      test_multi();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
